wavetable_loader: RTL

Byte-stream receiver that writes wavetable RAM, the write side of the 8192-sample RAM that the NCO reads. It accepts framed uploads of one 128-sample wave from the MCU interface and issues one RAM write per data byte at address {wave, sample}. It also reports which wave is being overwritten, so playback logic can avoid selecting it.

---
 rtl/wavetable_loader.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/wavetable_loader.sv
// Framed byte-stream loader for the wavetable RAM: SYNC, header(wave), 128 samples[, checksum].
// Define WAVETABLE_LOADER_CHECKSUM_EN to add the trailing checksum byte and CHECK state.
module wavetable_loader #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_ram_write_enable,
    output logic [12:0] o_ram_address,
    output logic [7:0]  o_ram_data,
    output logic        o_busy,
    output logic [5:0]  o_active_wave,
    output logic        o_done,
    output logic        o_error
);

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_CHECK, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_HEADER, S_DATA, S_DONE} state_t;
`endif

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic        we_q, we_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic        busy_q, busy_d;
    logic [5:0]  wave_q, wave_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [6:0]  sample_q, sample_d;
    logic [15:0] tmo_q, tmo_d;
    logic        accept;
    logic        in_frame;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    logic [7:0]  sum_q, sum_d;
`endif

    assign accept = i_byte_valid && ready_q;

    always_comb begin
        state_d  = state_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        wave_d   = wave_q;
        sample_d = sample_q;
        tmo_d    = 16'd0;
        error_d  = 1'b0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        sum_d    = sum_q;
        in_frame = (state_q == S_HEADER) || (state_q == S_DATA) || (state_q == S_CHECK);
`else
        in_frame = (state_q == S_HEADER) || (state_q == S_DATA);
`endif

        // An accepted byte always beats an expiring idle timer.
        if (in_frame) begin
            if (accept) begin
                tmo_d = 16'd0;
            end else if (tmo_q == TMO_LAST) begin
                error_d = 1'b1;
                state_d = S_IDLE;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept && (i_byte == SYNC_BYTE)) begin
                    state_d = S_HEADER;
                end
            end
            S_HEADER: begin
                if (accept) begin
                    if (i_byte[7:6] == 2'b00) begin
                        wave_d   = i_byte[5:0];
                        sample_d = 7'd0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                        sum_d    = 8'd0;
`endif
                        state_d  = S_DATA;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d   = 1'b1;
                    addr_d = {wave_q, sample_q};
                    data_d = i_byte;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + i_byte;
`endif
                    // Counter stops at 127 so a frame can never spill into the next wave.
                    if (sample_q == 7'd127) begin
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        sample_d = sample_q + 7'd1;
                    end
                end
            end
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    if (i_byte == sum_q) begin
                        state_d = S_DONE;
                    end else begin
                        error_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Busy stays up through the error pulse of an aborted frame, then drops.
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        busy_d = (state_d == S_DATA) || (state_d == S_CHECK) || (state_d == S_DONE)
                 || (error_d && busy_q);
`else
        busy_d = (state_d == S_DATA) || (state_d == S_DONE) || (error_d && busy_q);
`endif
        done_d  = (state_d == S_DONE);
        ready_d = (state_d != S_DONE);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= 13'd0;
            data_q   <= 8'd0;
            busy_q   <= 1'b0;
            wave_q   <= 6'd0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            sample_q <= 7'd0;
            tmo_q    <= 16'd0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            sum_q    <= 8'd0;
`endif
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            busy_q   <= busy_d;
            wave_q   <= wave_d;
            done_q   <= done_d;
            error_q  <= error_d;
            sample_q <= sample_d;
            tmo_q    <= tmo_d;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign o_byte_ready       = ready_q;
    assign o_ram_write_enable = we_q;
    assign o_ram_address      = addr_q;
    assign o_ram_data         = data_q;
    assign o_busy             = busy_q;
    assign o_active_wave      = wave_q;
    assign o_done             = done_q;
    assign o_error            = error_q;

endmodule
